// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA raster generator family.
package vga_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } vga_state_t;

   typedef struct packed {
      int unsigned active;
      int unsigned fp;
      int unsigned sync;
      int unsigned bp;
   } vga_timing_t;

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;
   localparam int unsigned DEF_FC_W     = 16;

   localparam vga_timing_t VGA_640X480_H = '{DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP};
   localparam vga_timing_t VGA_640X480_V = '{DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP};

   function automatic int unsigned timing_total(vga_timing_t t);
      return t.active + t.fp + t.sync + t.bp;
   endfunction

endpackage

// File: rtl/vga_axis_timer.sv
// One raster axis: wrapping position counter with sync decode registered from the next count,
// so the sync output lines up with the count it describes.
module vga_axis_timer
   import vga_pkg::*;
#(
   parameter int unsigned ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned FP     = DEF_H_FP,
   parameter int unsigned SYNC   = DEF_H_SYNC,
   parameter int unsigned BP     = DEF_H_BP,
   parameter bit          POL    = 1'b0,
   localparam vga_timing_t TIMING = '{ACTIVE, FP, SYNC, BP},
   localparam int unsigned TOTAL  = timing_total(TIMING),
   localparam int unsigned W      = $clog2(TOTAL)
)(
   input  logic         clk,
   input  logic         reset_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count,
   output logic [W-1:0] next_count,
   output logic         active_next,
   output logic         sync,
   output logic         wrap
);

   localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
   localparam logic [W-1:0] ACTIVE_END = W'(ACTIVE);
   localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
   localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FP + SYNC);

   always_comb begin
      wrap = inc && (count == LAST);
      if (clr) begin
         next_count = '0;
      end else if (wrap) begin
         next_count = '0;
      end else if (inc) begin
         next_count = count + 1'b1;
      end else begin
         next_count = count;
      end
   end

   assign active_next = (next_count < ACTIVE_END);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
         sync  <= ~POL;
      end else begin
         count <= next_count;
         sync  <= ((next_count >= SYNC_START) && (next_count < SYNC_END)) ? POL : ~POL;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator driven by a pixel clock-enable, with run/stop control
// that always lets a started frame finish before going idle.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0,
   parameter int unsigned FC_W     = DEF_FC_W,
   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int unsigned XW      = $clog2(H_TOTAL),
   localparam int unsigned YW      = $clog2(V_TOTAL)
)(
   input  logic            clk,
   input  logic            reset_n,
   input  logic            pix_ce,
   input  logic            run,
   output logic [XW-1:0]   x,
   output logic [YW-1:0]   y,
   output logic            hsync,
   output logic            vsync,
   output logic            de,
   output logic            line_start,
   output logic            frame_start,
   output logic [FC_W-1:0] frame_cnt,
   output logic            busy
);

   if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
       V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 || FC_W < 1) begin : g_param_check
      $error("vga_timing_gen: timing parameters must be nonzero and FC_W must be at least 1");
   end

   vga_state_t    state;
   vga_state_t    state_next;
   logic          h_inc;
   logic          ctr_clr;
   logic          h_wrap;
   logic          v_wrap;
   logic [XW-1:0] h_next;
   logic [YW-1:0] v_next;
   logic          h_active_next;
   logic          v_active_next;

   // Counters only move while a frame is in flight; IDLE pins them at the origin.
   assign h_inc   = pix_ce && (state != IDLE);
   assign ctr_clr = pix_ce && (state == IDLE);

   vga_axis_timer #(
      .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL)
   ) u_h_timer (
      .clk(clk), .reset_n(reset_n), .inc(h_inc), .clr(ctr_clr),
      .count(x), .next_count(h_next), .active_next(h_active_next),
      .sync(hsync), .wrap(h_wrap)
   );

   vga_axis_timer #(
      .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL)
   ) u_v_timer (
      .clk(clk), .reset_n(reset_n), .inc(h_wrap), .clr(ctr_clr),
      .count(y), .next_count(v_next), .active_next(v_active_next),
      .sync(vsync), .wrap(v_wrap)
   );

   // v_wrap marks the last pixel of the frame being consumed on this pix_ce.
   always_comb begin
      state_next = state;
      if (pix_ce) begin
         case (state)
            IDLE:    if (run) state_next = RUN;
            RUN:     if (!run) state_next = v_wrap ? IDLE : DRAIN;
            DRAIN: begin
               if (run) begin
                  state_next = RUN;
               end else if (v_wrap) begin
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Qualifiers are decoded from the next position and state so they land with x,y.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         de          <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         busy        <= 1'b0;
         frame_cnt   <= '0;
      end else if (pix_ce) begin
         de          <= h_active_next && v_active_next && (state_next == RUN);
         line_start  <= (h_next == '0) && (state_next == RUN);
         frame_start <= (h_next == '0) && (v_next == '0) && (state_next == RUN);
         busy        <= (state_next != IDLE);
         if (v_wrap) begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: a default 640x480 instance and a tiny 8x6 instance run side by side
// against a pixel-index reference model.
module tb_vga_timing_gen;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_DRAIN = 2;

   logic clk = 1'b0;
   logic reset_n;
   logic pix_ce;
   logic run_a;
   logic run_b;

   logic [9:0]  x_a, y_a;
   logic        hs_a, vs_a, de_a, ls_a, fs_a, busy_a;
   logic [15:0] fc_a;

   logic [2:0]  x_b, y_b;
   logic        hs_b, vs_b, de_b, ls_b, fs_b, busy_b;
   logic [1:0]  fc_b;

   int total = 0;
   int bad   = 0;

   int ha[2]   = '{640, 4};
   int hfp[2]  = '{16, 1};
   int hsw[2]  = '{96, 2};
   int hbp[2]  = '{48, 1};
   int va[2]   = '{480, 3};
   int vfp[2]  = '{10, 1};
   int vsw[2]  = '{2, 1};
   int vbp[2]  = '{33, 1};
   int hpol[2] = '{0, 1};
   int vpol[2] = '{0, 0};
   int fcw[2]  = '{16, 2};

   int m_mode[2];
   int m_pos[2];
   int m_cnt[2];

   always #5 clk = ~clk;

   vga_timing_gen u_a (
      .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .run(run_a),
      .x(x_a), .y(y_a), .hsync(hs_a), .vsync(vs_a), .de(de_a),
      .line_start(ls_a), .frame_start(fs_a), .frame_cnt(fc_a), .busy(busy_a)
   );

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b0), .FC_W(2)
   ) u_b (
      .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .run(run_b),
      .x(x_b), .y(y_b), .hsync(hs_b), .vsync(vs_b), .de(de_b),
      .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b), .busy(busy_b)
   );

   // The model tracks a linear pixel index within the frame; x and y fall out by division.
   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_mode[i] = M_IDLE;
         m_pos[i]  = 0;
         m_cnt[i]  = 0;
      end
   endtask

   task automatic model_step(int i, bit ce, bit r);
      int  len;
      bit  last;
      if (!ce) return;
      len = (ha[i] + hfp[i] + hsw[i] + hbp[i]) * (va[i] + vfp[i] + vsw[i] + vbp[i]);
      if (m_mode[i] == M_IDLE) begin
         if (r) m_mode[i] = M_RUN;
         return;
      end
      last = (m_pos[i] == len - 1);
      m_pos[i] = last ? 0 : m_pos[i] + 1;
      if (last) m_cnt[i]++;
      if (m_mode[i] == M_RUN && !r) begin
         m_mode[i] = last ? M_IDLE : M_DRAIN;
      end else if (m_mode[i] == M_DRAIN) begin
         if (r) m_mode[i] = M_RUN;
         else if (last) m_mode[i] = M_IDLE;
      end
   endtask

   function automatic logic [63:0] pack(logic [15:0] xv, logic [15:0] yv, logic [15:0] fc,
                                        logic hs, logic vs, logic d, logic ls, logic fs, logic bz);
      return {xv, yv, fc, 10'd0, hs, vs, d, ls, fs, bz};
   endfunction

   function automatic logic [63:0] expected(int i);
      int ht, xx, yy;
      bit on, hp, vp, hs, vs, d, ls, fs;
      ht = ha[i] + hfp[i] + hsw[i] + hbp[i];
      xx = m_pos[i] % ht;
      yy = m_pos[i] / ht;
      hp = (hpol[i] != 0);
      vp = (vpol[i] != 0);
      on = (m_mode[i] != M_IDLE);
      hs = (on && xx >= ha[i] + hfp[i] && xx < ha[i] + hfp[i] + hsw[i]) ? hp : ~hp;
      vs = (on && yy >= va[i] + vfp[i] && yy < va[i] + vfp[i] + vsw[i]) ? vp : ~vp;
      d  = (m_mode[i] == M_RUN) && (xx < ha[i]) && (yy < va[i]);
      ls = (m_mode[i] == M_RUN) && (xx == 0);
      fs = (m_mode[i] == M_RUN) && (m_pos[i] == 0);
      return pack(16'(xx), 16'(yy), 16'(m_cnt[i] % (1 << fcw[i])), hs, vs, d, ls, fs, on);
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(string tag);
      chk({tag, "/a"}, pack(x_a, y_a, fc_a, hs_a, vs_a, de_a, ls_a, fs_a, busy_a), expected(0));
      chk({tag, "/b"}, pack(x_b, y_b, fc_b, hs_b, vs_b, de_b, ls_b, fs_b, busy_b), expected(1));
   endtask

   task automatic applyStimulus(bit ce, bit ra, bit rb);
      pix_ce = ce;
      run_a  = ra;
      run_b  = rb;
      @(posedge clk);
      model_step(0, ce, ra);
      model_step(1, ce, rb);
      #1;
      checkOutput("cycle");
   endtask

   initial begin
      int   rises, last_c, per, hs_low, hs_x, n, hsn, vsn, dn, lsn, fsn;
      logic prev_ls;
      bit   ra, rb;

      reset_n = 1'b0;
      pix_ce  = 1'b0;
      run_a   = 1'b0;
      run_b   = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset");
      reset_n = 1'b1;

      // Default mode, pix_ce every cycle: line period and hsync placement.
      rises = 0; last_c = 0; per = -1; hs_low = 0; hs_x = -1; prev_ls = ls_a;
      for (int c = 0; c < 1700; c++) begin
         applyStimulus(1'b1, 1'b1, 1'b0);
         if (ls_a && !prev_ls) begin
            rises++;
            if (rises == 2) per = c - last_c;
            last_c = c;
         end else if (rises == 1 && hs_a == 1'b0) begin
            hs_low++;
            if (hs_x < 0) hs_x = int'(x_a);
         end
         prev_ls = ls_a;
      end
      chk("line_period", per, 800);
      chk("hsync_width", hs_low, 96);
      chk("hsync_first_x", hs_x, 656);

      // pix_ce one cycle in three stretches everything by three.
      rises = 0; per = -1; hs_low = 0; prev_ls = ls_a;
      for (int c = 0; c < 5400; c++) begin
         applyStimulus((c % 3) == 0, 1'b1, 1'b0);
         if (ls_a && !prev_ls) begin
            rises++;
            if (rises == 2) per = c - last_c;
            last_c = c;
         end else if (rises == 1 && hs_a == 1'b0) begin
            hs_low++;
         end
         prev_ls = ls_a;
      end
      chk("line_period_ce3", per, 2400);
      chk("hsync_width_ce3", hs_low, 288);

      // Small mode: per-frame strobe/de counts and frame counter wrap.
      dn = 0; lsn = 0; fsn = 0;
      for (int k = 0; k < 193; k++) begin
         applyStimulus(1'b1, 1'b1, 1'b1);
         if (k < 48) begin
            dn  += int'(de_b);
            lsn += int'(ls_b);
            fsn += int'(fs_b);
         end
         if (k == 191) chk("fc_before_wrap", fc_b, 3);
         if (k == 192) chk("fc_wrap", fc_b, 0);
      end
      chk("de_per_frame", dn, 12);
      chk("ls_per_frame", lsn, 6);
      chk("fs_per_frame", fsn, 1);

      // Drop run mid-frame at x=1,y=2.
      for (int k = 0; k < 16; k++) applyStimulus(1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0);
      chk("drain_de", de_b, 0);
      chk("drain_busy", busy_b, 1);
      n = 0; hsn = 0; vsn = 0; dn = 0;
      do begin
         applyStimulus(1'b1, 1'b1, 1'b0);
         n++;
         if (hs_b) hsn++;
         if (!vs_b) vsn++;
         if (de_b) dn++;
      end while (busy_b && n < 100);
      chk("drain_ticks", n, 31);
      chk("drain_hsync", hsn, 8);
      chk("drain_vsync", vsn, 8);
      chk("drain_de_cnt", dn, 0);
      chk("idle_x", x_b, 0);
      chk("idle_y", y_b, 0);
      chk("idle_fc", fc_b, 1);

      // Run falls exactly on the last pixel of the frame.
      applyStimulus(1'b1, 1'b1, 1'b1);
      chk("restart_fs", fs_b, 1);
      for (int k = 0; k < 47; k++) applyStimulus(1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0);
      chk("end_fs", fs_b, 0);
      chk("end_busy", busy_b, 0);
      chk("end_fc", fc_b, 2);
      chk("end_x", x_b, 0);

      // Reassert run during DRAIN: raster must not jump.
      applyStimulus(1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1);
      chk("resume_x", x_b, 5);
      chk("resume_y", y_b, 1);
      chk("resume_busy", busy_b, 1);
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1, 1'b1);
      chk("resume_de", de_b, 1);
      chk("resume_ls", ls_b, 1);

      // Random pix_ce and run toggling.
      ra = 1'b1; rb = 1'b1;
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 19) == 0) rb = ~rb;
         if ($urandom_range(0, 49) == 0) ra = ~ra;
         applyStimulus(1'($urandom_range(0, 1)), ra, rb);
      end

      // Asynchronous reset between clock edges, mid-line.
      for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b1, 1'b1);
      #3;
      reset_n = 1'b0;
      #1;
      model_reset();
      checkOutput("async_reset");
      chk("async_reset_fc", fc_b, 0);
      #1;
      reset_n = 1'b1;
      for (int k = 0; k < 100; k++) applyStimulus(1'b1, 1'b1, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
